// File: rtl/uart_tx_fifo_if.sv
// Byte-feed handshake into the buffered UART transmitter.
// The producer drives valid/byte; the transmitter answers with ready.
interface uart_tx_fifo_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (output in_valid, output in_byte, input in_ready);
    modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a small FIFO over valid/ready
// and are serialised LSB first onto an idle-high line.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 218,
    parameter int DEPTH        = 4
) (
    input  logic          reset,
    input  logic          clock,
    uart_tx_fifo_if.slave feed,
    output logic          tx,
    output logic          tx_busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0]    LAST_TICK  = 8'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    shift;
    logic [7:0]    timer;
    logic [2:0]    bit_index;
    logic          full;
    logic          push;
    logic          pop;
    logic          bit_end;

    // A full FIFO refuses writes even when a pop frees a slot on the same edge.
    assign full          = (count == FULL_COUNT);
    assign feed.in_ready = !full;
    assign push          = feed.in_valid && !full;
    assign bit_end       = (timer == LAST_TICK);
    assign pop           = (count != '0) && ((state == IDLE) || (state == STOP && bit_end));
    assign tx_busy       = (state != IDLE) || (count != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= feed.in_byte;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // tx is loaded with the level of the state being entered, so it changes
    // on the same edge as the transition and never glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            shift     <= '0;
            timer     <= '0;
            bit_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    tx    <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer     <= '0;
                        bit_index <= '0;
                        state     <= DATA;
                        tx        <= shift[0];
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_index == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                            tx        <= shift[1];
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle tables for exact timing plus a
// serial-decoding scoreboard that compares every received frame to accepted bytes.
module tb_uart_tx_fifo;
    localparam int CPB   = 218;
    localparam int FRAME = 10 * CPB;

    typedef struct {
        int   cycle;
        logic tx;
        logic busy;
        logic ready;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic tx;
    logic tx_busy;
    logic tx2;
    logic tx_busy2;

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int frames_seen = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_fifo_if ifc ();
    uart_tx_fifo_if ifc2 ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
        .reset   (reset),
        .clock   (clock),
        .feed    (ifc.slave),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(2), .DEPTH(4)) dut2 (
        .reset   (reset),
        .clock   (clock),
        .feed    (ifc2.slave),
        .tx      (tx2),
        .tx_busy (tx_busy2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycle(input int target);
        do @(negedge clock); while (cyc < target);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        ifc.in_valid = 1'b1;
        ifc.in_byte  = b;
        @(posedge clock);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    // Scoreboard: every byte the DUT accepts is expected on the line, in order.
    always @(negedge clock) begin
        if (!reset && ifc.in_valid && ifc.in_ready) begin
            exp_q.push_back(ifc.in_byte);
        end
    end

    // Receiver model: samples each bit mid-period; a reset anywhere in the frame voids it.
    initial begin : rx_model
        logic [7:0] data;
        logic [7:0] want;
        logic       stop_bit;
        bit         aborted;
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                aborted = 1'b0;
                starts.push_back(cyc);
                repeat (CPB / 2) begin
                    @(negedge clock);
                    if (reset) aborted = 1'b1;
                end
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) begin
                        @(negedge clock);
                        if (reset) aborted = 1'b1;
                    end
                    data[b] = tx;
                end
                repeat (CPB) begin
                    @(negedge clock);
                    if (reset) aborted = 1'b1;
                end
                stop_bit = tx;
                if (!aborted) begin
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL unexpected_frame: got %02h, expected no frame", data);
                    end else begin
                        want = exp_q.pop_front();
                        checkOutput("frame_data", 32'(data), 32'(want));
                        checkOutput("stop_bit", 32'(stop_bit), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        vec_t       vecs[12];
        int         t0;
        int         base;
        int         low_count;
        logic [9:0] fb;

        // Single 0x55 frame: start low, bits 1,0,1,0,... then stop, each CPB cycles.
        vecs[0]  = '{1,            1'b1, 1'b1, 1'b1};
        vecs[1]  = '{2,            1'b0, 1'b1, 1'b1};
        vecs[2]  = '{CPB + 1,      1'b0, 1'b1, 1'b1};
        vecs[3]  = '{CPB + 2,      1'b1, 1'b1, 1'b1};
        vecs[4]  = '{2 * CPB + 1,  1'b1, 1'b1, 1'b1};
        vecs[5]  = '{2 * CPB + 2,  1'b0, 1'b1, 1'b1};
        vecs[6]  = '{8 * CPB + 2,  1'b0, 1'b1, 1'b1};
        vecs[7]  = '{9 * CPB + 1,  1'b0, 1'b1, 1'b1};
        vecs[8]  = '{9 * CPB + 2,  1'b1, 1'b1, 1'b1};
        vecs[9]  = '{10 * CPB + 1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{10 * CPB + 2, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{10 * CPB + 3, 1'b1, 1'b0, 1'b1};

        ifc.in_valid  = 1'b0;
        ifc.in_byte   = 8'h00;
        ifc2.in_valid = 1'b0;
        ifc2.in_byte  = 8'h00;

        #1 reset = 1'b1;
        #2;
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_ready", 32'(ifc.in_ready), 32'd1);
        checkOutput("reset_busy", 32'(tx_busy), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        $display("[TB] single byte 0x55");
        applyStimulus(8'h55);
        t0 = cyc;
        for (int i = 0; i < 12; i++) begin
            waitCycle(t0 + vecs[i].cycle - 1);
            checkOutput($sformatf("single_tx@%0d", vecs[i].cycle), 32'(tx), 32'(vecs[i].tx));
            checkOutput($sformatf("single_busy@%0d", vecs[i].cycle), 32'(tx_busy), 32'(vecs[i].busy));
            checkOutput($sformatf("single_ready@%0d", vecs[i].cycle), 32'(ifc.in_ready), 32'(vecs[i].ready));
        end
        @(posedge clock);
        #1;

        $display("[TB] back-to-back 0xA5 0x3C");
        starts.delete();
        base = frames_seen;
        ifc.in_valid = 1'b1;
        ifc.in_byte  = 8'hA5;
        @(posedge clock);
        #1 ifc.in_byte = 8'h3C;
        @(posedge clock);
        #1 ifc.in_valid = 1'b0;
        t0 = cyc;
        waitCycle(t0 + 2 * FRAME + 50);
        checkOutput("b2b_frames", 32'(frames_seen - base), 32'd2);
        checkOutput("b2b_starts", 32'(starts.size()), 32'd2);
        if (starts.size() >= 2) begin
            checkOutput("b2b_period", 32'(starts[1] - starts[0]), 32'(FRAME));
        end
        checkOutput("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;

        $display("[TB] FIFO full with 0x01..0x06");
        base = frames_seen;
        ifc.in_valid = 1'b1;
        ifc.in_byte  = 8'h01;
        @(posedge clock);
        #1 t0 = cyc;
        for (int i = 2; i <= 6; i++) begin
            ifc.in_byte = 8'(i);
            if (i == 6) begin
                @(negedge clock);
                checkOutput("full_ready_low", 32'(ifc.in_ready), 32'd0);
            end
            @(posedge clock);
            #1;
        end
        ifc.in_valid = 1'b0;
        waitCycle(t0 + 2181 - 1);
        checkOutput("full_ready_before_pop", 32'(ifc.in_ready), 32'd0);
        waitCycle(t0 + 2182 - 1);
        checkOutput("full_ready_after_pop", 32'(ifc.in_ready), 32'd1);
        waitCycle(t0 + 5 * FRAME + 50);
        checkOutput("full_frames", 32'(frames_seen - base), 32'd5);
        checkOutput("full_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("full_busy_done", 32'(tx_busy), 32'd0);
        @(posedge clock);
        #1;

        $display("[TB] reset during data bit 3 of 0xF0");
        base = frames_seen;
        applyStimulus(8'hF0);
        t0 = cyc;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        waitCycle(t0 + 950 - 1);
        checkOutput("rst_bit3_low", 32'(tx), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rst_tx_high", 32'(tx), 32'd1);
        checkOutput("rst_ready_high", 32'(ifc.in_ready), 32'd1);
        checkOutput("rst_busy_low", 32'(tx_busy), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        low_count = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clock);
            if (tx !== 1'b1) low_count++;
        end
        checkOutput("rst_no_low_after", 32'(low_count), 32'd0);
        checkOutput("rst_no_frames", 32'(frames_seen - base), 32'd0);
        checkOutput("rst_busy_after", 32'(tx_busy), 32'd0);
        @(posedge clock);
        #1;

        $display("[TB] loopback 0x00 0xFF 0x81");
        base = frames_seen;
        ifc.in_valid = 1'b1;
        ifc.in_byte  = 8'h00;
        @(posedge clock);
        #1 ifc.in_byte = 8'hFF;
        @(posedge clock);
        #1 ifc.in_byte = 8'h81;
        @(posedge clock);
        #1 ifc.in_valid = 1'b0;
        t0 = cyc;
        waitCycle(t0 + 3 * FRAME + 50);
        checkOutput("loop_frames", 32'(frames_seen - base), 32'd3);
        checkOutput("loop_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;

        $display("[TB] minimum period, 0xC3 at 2 clocks per bit");
        fb = {1'b1, 8'hC3, 1'b0};
        ifc2.in_valid = 1'b1;
        ifc2.in_byte  = 8'hC3;
        @(posedge clock);
        #1 ifc2.in_valid = 1'b0;
        t0 = cyc;
        for (int c = 2; c <= 21; c++) begin
            waitCycle(t0 + c - 1);
            checkOutput($sformatf("min_tx@%0d", c), 32'(tx2), 32'(fb[(c - 2) / 2]));
        end
        waitCycle(t0 + 22 - 1);
        checkOutput("min_idle_tx", 32'(tx2), 32'd1);
        checkOutput("min_idle_busy", 32'(tx_busy2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the 8N1 serial link: it accepts bytes over a valid/ready handshake into a small FIFO and serialises them onto a single idle-high line. Each frame is one start bit (0), eight data bits LSB first, and one stop bit (1). It is the transmit-side counterpart of the design's UART receiver and uses the same bit period, so `tx` may be looped straight into the receiver's `rx`.

## Interface
- `CLKS_PER_BIT`, default 218: clock cycles per serial bit.
  - Legal range 2..256.
  - Internal bit timer is 8 bits and counts 0..CLKS_PER_BIT-1.
- `DEPTH`, default 4: FIFO entries. Power of two, ≥2.
- `reset` input 1: reset, asynchronous, active-high.
- `clock` input 1: clock.
- `in_valid` input 1: `in_byte` holds a byte to send.
- `in_byte` input 8: data byte.
- `in_ready` output 1: FIFO can accept a byte (`!full`).
- `tx` output 1: serial line, registered, idle high.
- `tx_busy` output 1: high when a frame is in progress or the FIFO is non-empty.

## Operation
- **Accept:** a byte is written on any rising edge where `in_valid && in_ready`. Bytes are transmitted in acceptance order.
- **FIFO:** read/write pointers plus a count register, width clog2(DEPTH)+1. `in_ready = (count != DEPTH)`.
- **Full FIFO:** when the FIFO is full, a write is refused even if a pop occurs on the same edge.
- **Simultaneous write and pop:** count is unchanged; both pointers advance.
- **FSM states:**
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0].
  - STOP: tx=1.
- **Bit timer:** cleared on every state entry and on every bit boundary. A bit ends when timer == CLKS_PER_BIT-1.
- **IDLE:**
  - FIFO non-empty: pop into `shift`, clear timer, go to START.
  - Otherwise: stay in IDLE.
- **START:** at the end of the bit, go to DATA with bit_index=0.
- **DATA:** at the end of each bit, shift right (`shift <= {1'b0, shift[7:1]}`) and increment bit_index. After the bit with index 7 ends, go to STOP.
- **STOP:** at the end of the bit:
  - FIFO non-empty: pop, go directly to START (no idle gap).
  - Otherwise: go to IDLE.
- `tx` is a flop loaded with the value for the next state on the same edge as the transition. It never glitches.
- `tx_busy = (state != IDLE) || (count != 0)`, combinational from registers.
- **In-flight bytes:** a byte already popped into `shift` is unaffected by later FIFO writes.

## Timing
- **Reset values** (asynchronous, immediate):
  - state=IDLE, tx=1
  - count=0, pointers=0, shift=0, timer=0, bit_index=0
  - in_ready=1, tx_busy=0
- **Reset mid-frame:** `tx` returns high immediately and all queued bytes are discarded. After release, no frame starts until a new byte is accepted.
- **Latency:** byte accepted at end of cycle 0 (FIFO previously empty, FSM idle):
  - cycle 1: FSM pops;
  - cycle 2: tx=0 (start bit begins);
  - start bit occupies cycles 2..CLKS_PER_BIT+1.
- **Frame length:** exactly 10*CLKS_PER_BIT cycles from the first low cycle to the end of the stop bit.
- **Back-to-back frames:** frame period is exactly 10*CLKS_PER_BIT cycles; the next start bit begins the cycle after the stop bit ends.
- **in_ready release:** when the FIFO is full, `in_ready` rises the cycle after the pop edge.
- **tx_busy release:** `tx_busy` falls in the first IDLE cycle after the final stop bit, if no write occurs on that edge.

## Test plan
- **Single byte:**
  - Stimulus: one-cycle `in_valid`, `in_byte`=0x55, CLKS_PER_BIT=218.
  - Response: tx low at cycle 2, then bits 1,0,1,0,1,0,1,0, then stop 1, each held 218 cycles; tx_busy low after cycle 2181.
- **Back-to-back:**
  - Stimulus: write 0xA5 and 0x3C on consecutive cycles.
  - Response: the second start bit begins exactly 2180 cycles after the first; no extra high cycles between frames; data LSB first.
- **FIFO full:**
  - Stimulus: hold `in_valid` for 6 cycles with bytes 0x01..0x06, DEPTH=4.
  - Response:
    - 0x01 is popped into `shift`; 0x02..0x05 fill the FIFO; `in_ready` is low while 0x06 is presented, so 0x06 is not accepted.
    - Exactly 5 frames, 0x01..0x05, in order.
- **Reset mid-frame:**
  - Stimulus: assert `reset` during the DATA bit 3 of 0xF0, with 2 bytes queued.
  - Response: tx=1 and in_ready=1 immediately; no further frames after release.
- **Loopback:**
  - Stimulus: connect `tx` to the receiver's `rx`; send 0x00, 0xFF, 0x81 back-to-back.
  - Response: the receiver strobes three times with `rx_byte` = 0x00, 0xFF, 0x81.
- **Minimum period:**
  - Stimulus: CLKS_PER_BIT=2, send 0xC3.
  - Response: a 20-cycle frame with a correct bit pattern.
